mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 mem_read, mem_write  input  1 each  memory-stage controls from the upstream pipeline control register.
REQ-005 func3_to_mem  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 addr  input  32  effective address; wdata  input  32  store data.
REQ-007 stall  output  1  freeze request to upstream pipeline registers.
REQ-008 rdata_out  output  32  extended load result.
REQ-009 misalign_err  output  1  one-cycle misaligned-access flag.
REQ-010 bus_req, bus_we  output  1 each  request strobe and write select.
REQ-011 bus_addr  output  32  word-aligned address; bus_be  output  4  byte enables; bus_wdata  output  32  lane-replicated data.
REQ-012 bus_ack  input  1  completion; bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-013 The FSM SHALL have states IDLE, REQ and DONE.
REQ-014 IDLE -> REQ when (mem_read|mem_write) is high and the access is legal; all bus outputs registered on entry to REQ.
REQ-015 REQ SHALL hold bus_req=1 and all bus outputs stable until bus_ack is sampled high, then go to DONE.
REQ-016 DONE -> IDLE unconditionally after one cycle.
REQ-017 stall = (IDLE & (mem_read|mem_write)) | REQ, combinationally; stall SHALL be low in DONE.
REQ-018 Minimum latency SHALL be 3 cycles from request to DONE when bus_ack is high on the first REQ cycle.
REQ-019 When mem_read and mem_write are both high, the access SHALL be a write.
REQ-020 Stores SHALL set bus_be as follows: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111. bus_wdata SHALL replicate the byte (x4) or half (x2) across lanes.
REQ-021 Loads SHALL set bus_be=1111.
REQ-022 On the bus_ack edge, the selected byte or half SHALL be extracted, sign-extended (B, H) or zero-extended (BU, HU), and registered into rdata_out; rdata_out SHALL hold until the next load completes.
REQ-023 Illegal func3 (011, 110, 111; or 1xx on a store) SHALL issue no bus access: IDLE -> DONE directly, rdata_out=0.
REQ-024 bus_req SHALL be 0 in IDLE and DONE; bus_ack outside REQ SHALL be ignored.

Reset
REQ-025 Reset SHALL force: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata_out=0, misalign_err=0.
REQ-026 Reset in REQ SHALL abort the access; an ack arriving after reset SHALL be ignored.

Configuration
REQ-027 With MEM_MISALIGN_TRAP_EN defined, a misaligned access (H with addr[0]=1; W with addr[1:0]!=0) SHALL issue no bus access, go IDLE -> DONE, and pulse misalign_err=1 in DONE with rdata_out=0.
REQ-028 Without MEM_MISALIGN_TRAP_EN, addr low bits SHALL be forced aligned for the access size, the access SHALL proceed normally, and misalign_err SHALL be tied to 0.

Structure
REQ-029 Package mem_pkg SHALL hold the state enum, func3 encodings and the bus width constant (32).
REQ-030 Sub-module mem_lane_align (combinational byte-enable, replication, extraction and extension) SHALL be instantiated once.

Verification
REQ-031 LW at addr 0x100, ack after 2 REQ cycles, bus_rdata 0xDEADBEEF -> stall high 3 cycles, rdata_out=0xDEADBEEF.
REQ-032 LB at 0x103, bus_rdata 0x80FF_0000 -> bus_be=1111, rdata_out=0xFFFFFF80; LBU -> 0x00000080.
REQ-033 SH at 0x102, wdata 0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-034 SW at 0x101 -> with MEM_MISALIGN_TRAP_EN: no bus_req, misalign_err pulse; without: bus_addr=0x100, bus_be=1111.
REQ-035 reset_n low during REQ, then bus_ack high -> bus_req=0 the next cycle, state IDLE, ack ignored, rdata_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
package mem_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_byte(input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_BU;
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return f3 == F3_H || f3 == F3_HU;
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3,
                                    input logic we);
    logic ok;
    ok = f3 == F3_B || f3 == F3_H || f3 == F3_W;
    if (!we)
      ok = ok || f3 == F3_BU || f3 == F3_HU;
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3,
                                         input logic [1:0] a);
    return (is_half(f3) && a[0]) ||
           (f3 == F3_W && a != 2'b00);
  endfunction

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] align_off(input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [1:0] o;
    o = a;
    if (is_half(f3))
      o = {a[1], 1'b0};
    else if (f3 == F3_W)
      o = 2'b00;
    return o;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic             i_we,
  input  logic [2:0]       i_st_f3,
  input  logic [1:0]       i_st_off,
  input  logic [BUS_W-1:0] i_wdata,
  input  logic [2:0]       i_ld_f3,
  input  logic [1:0]       i_ld_off,
  input  logic [BUS_W-1:0] i_rdata,
  output logic [3:0]       o_be,
  output logic [BUS_W-1:0] o_wdata,
  output logic [BUS_W-1:0] o_rdata
);

  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sgn;

  assign w_b   = 8'(i_rdata >> {i_ld_off, 3'b000});
  assign w_h   = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_sgn = ~i_ld_f3[2];

  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    unique case (1'b1)
      is_byte(i_st_f3): begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      is_half(i_st_f3): begin
        o_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
      end
    endcase
    if (!i_we)
      o_be = 4'hF;
  end

  always_comb begin
    o_rdata = i_rdata;
    unique case (1'b1)
      is_byte(i_ld_f3): o_rdata = {{24{w_b[7] & w_sgn}}, w_b};
      is_half(i_ld_f3): o_rdata = {{16{w_h[15] & w_sgn}}, w_h};
      default:          o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bus master: IDLE -> REQ -> DONE handshake with lane steering.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       func3_to_mem,
  input  logic [BUS_W-1:0] addr,
  input  logic [BUS_W-1:0] wdata,
  output logic             stall,
  output logic [BUS_W-1:0] rdata_out,
  output logic             misalign_err,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [3:0]       bus_be,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata
);

  state_t r_state, w_next;

  logic             r_we;
  logic [3:0]       r_be;
  logic [BUS_W-1:0] r_addr;
  logic [BUS_W-1:0] r_wdata;
  logic [BUS_W-1:0] r_rdata;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             w_req;
  logic             w_legal;
  logic             w_mis;
  logic             w_go;
  logic             w_idle;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [BUS_W-1:0] w_wdata;
  logic [BUS_W-1:0] w_rext;

  assign w_req   = mem_read | mem_write;
  assign w_legal = f3_legal(func3_to_mem, mem_write);
  assign w_off   = align_off(func3_to_mem, addr[1:0]);
  assign w_idle  = r_state == S_IDLE;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = f3_misaligned(func3_to_mem, addr[1:0]);

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_mis <= 1'b0;
    else
      r_mis <= w_idle & w_req & w_legal & w_mis;
  end

  assign misalign_err = r_mis;
`else
  assign w_mis        = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign w_go = w_idle & w_req & w_legal & ~w_mis;

  mem_lane_align u_lane (
    .i_we     (mem_write),
    .i_st_f3  (func3_to_mem),
    .i_st_off (w_off),
    .i_wdata  (wdata),
    .i_ld_f3  (r_f3),
    .i_ld_off (r_off),
    .i_rdata  (bus_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rext)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = w_go ? S_REQ : S_DONE;
      S_REQ:  if (bus_ack) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall   = (w_idle & w_req) | (r_state == S_REQ);
    bus_req = r_state == S_REQ;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_rdata <= '0;
    end else begin
      if (w_go) begin
        r_we    <= mem_write;
        r_be    <= w_be;
        r_addr  <= {addr[31:2], 2'b00};
        r_wdata <= w_wdata;
        r_f3    <= func3_to_mem;
        r_off   <= w_off;
      end
      // Rejected accesses (illegal or trapped) complete with a zero result.
      if (w_idle & w_req & ~w_go)
        r_rdata <= '0;
      else if (r_state == S_REQ && bus_ack && !r_we)
        r_rdata <= w_rext;
    end
  end

  assign bus_we    = r_we;
  assign bus_be    = r_be;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign rdata_out = r_rdata;

endmodule
